// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle radix-2 restoring divider for the RV64M divide group
//            (DIV/DIVU/REM/REMU and their W forms). One operation in flight,
//            valid/ready on both sides, flush kills the current operation.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    // Quotient bits resolved per CALC cycle; 1, 2 or 4
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_FIXUP   = 3'd2,
        S_SPECIAL = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [6:0]  c_N64  = 7'(64 / BITS_PER_CYCLE);
    localparam logic [6:0]  c_N32  = 7'(32 / BITS_PER_CYCLE);
    localparam logic [63:0] c_ONES = '1;
    localparam logic [63:0] c_MIN64 = 64'h8000_0000_0000_0000;

    state_t      r_state;
    logic        r_is_rem;     // op selects remainder
    logic        r_word;
    logic        r_neg_q;      // quotient needs negation in FIXUP
    logic        r_neg_r;      // remainder needs negation in FIXUP
    logic        r_zero;       // special case is divide-by-zero (else overflow)
    logic [6:0]  r_cnt;
    logic [63:0] r_quo;        // dividend shifting out / quotient shifting in
    logic [64:0] r_rem;
    logic [63:0] r_div;        // divisor magnitude
    logic [63:0] r_result;
    logic        r_out_valid;

    // Operand decode at the accept boundary
    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_a_mag;
    logic [63:0] w_b_mag;
    logic        w_b_zero;
    logic        w_ovf;

    // Iteration and result shaping
    logic [64:0] w_rem_nxt;
    logic [63:0] w_quo_nxt;
    logic [65:0] w_diff;
    logic [64:0] w_shift;
    logic [63:0] w_q_fix;
    logic [63:0] w_r_fix;
    logic [63:0] w_pre;
    logic [63:0] w_final;

    assign in_ready  = (r_state == S_IDLE) && !flush;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    // Sign-extend/zero-extend W operands, take magnitudes, detect special cases
    always_comb begin
        w_signed = ~op[0];
        if (word) begin
            w_a_ext = w_signed ? {{32{dividend[31]}}, dividend[31:0]} : {32'b0, dividend[31:0]};
            w_b_ext = w_signed ? {{32{divisor[31]}},  divisor[31:0]}  : {32'b0, divisor[31:0]};
            w_ovf   = w_signed && (dividend[31:0] == 32'h8000_0000) && (divisor[31:0] == 32'hFFFF_FFFF);
        end else begin
            w_a_ext = dividend;
            w_b_ext = divisor;
            w_ovf   = w_signed && (dividend == c_MIN64) && (divisor == c_ONES);
        end
        w_a_neg  = w_signed & w_a_ext[63];
        w_b_neg  = w_signed & w_b_ext[63];
        w_a_mag  = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
        w_b_mag  = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;
        w_b_zero = (w_b_ext == 64'd0);
    end

    // BITS_PER_CYCLE restoring shift/trial-subtract steps chained in one cycle
    always_comb begin
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        w_diff    = '0;
        w_shift   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_shift = {w_rem_nxt[63:0], w_quo_nxt[63]};
            // Borrow out of bit 65 means the divisor did not fit
            w_diff  = {w_rem_nxt, w_quo_nxt[63]} - {2'b00, r_div};
            w_quo_nxt = {w_quo_nxt[62:0], ~w_diff[65]};
            w_rem_nxt = w_diff[65] ? w_shift : w_diff[64:0];
        end
    end

    // Sign correction, quotient/remainder select and W sign-extension
    always_comb begin
        w_q_fix = r_neg_q ? (64'd0 - r_quo) : r_quo;
        w_r_fix = r_neg_r ? (64'd0 - r_rem[63:0]) : r_rem[63:0];
        if (r_state == S_SPECIAL) begin
            // r_quo holds the original (extended) dividend in special cases
            if (r_is_rem) w_pre = r_zero ? r_quo : 64'd0;
            else          w_pre = r_zero ? c_ONES : r_quo;
        end else begin
            w_pre = r_is_rem ? w_r_fix : w_q_fix;
        end
        w_final = r_word ? {{32{w_pre[31]}}, w_pre[31:0]} : w_pre;
    end

    // Control FSM with registered result and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_rem    <= 1'b0;
            r_word      <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_is_rem <= op[1];
                        r_word   <= word;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_zero   <= w_b_zero;
                        r_rem    <= '0;
                        r_div    <= w_b_mag;
                        if (w_b_zero || w_ovf) begin
                            r_quo   <= word ? {{32{dividend[31]}}, dividend[31:0]} : dividend;
                            r_state <= S_SPECIAL;
                        end else begin
                            // W operands sit in the top half so 32 shifts consume them
                            r_quo   <= word ? {w_a_mag[31:0], 32'b0} : w_a_mag;
                            r_cnt   <= word ? c_N32 : c_N64;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - 7'd1;
                    if (r_cnt == 7'd1) r_state <= S_FIXUP;
                end
                S_FIXUP, S_SPECIAL: begin
                    r_result    <= w_final;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit (BITS_PER_CYCLE = 1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        word;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] c_DIV = 2'd0, c_DIVU = 2'd1, c_REM = 2'd2, c_REMU = 2'd3;

    div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Drive one request; lat = number of cycles after the accept edge until
    // out_valid is seen (sampled mid-cycle), -1 if it never appears.
    task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input bit ack,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        op = o; word = w; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        res = result;
        if (ack) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'd0; word = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 64'd0)
            $display("FAIL reset_state: out_valid=%b result=%h required 0/0", out_valid, result);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_signed();
        logic [63:0] r; int lat;
        run_op(c_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg7_2: got %h required %h", r, 64'hFFFF_FFFF_FFFF_FFFD);
        else n_pass++;
        n_checks++;
        if (lat !== 66) $display("FAIL lat_64bit: got %0d required 66", lat);
        else n_pass++;
        run_op(c_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rem_neg7_2: got %h required %h", r, 64'hFFFF_FFFF_FFFF_FFFF);
        else n_pass++;
        run_op(c_DIV, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL div_20_neg3: got %h required %h", r, 64'hFFFF_FFFF_FFFF_FFFA);
        else n_pass++;
        run_op(c_REM, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'd2) $display("FAIL rem_20_neg3: got %h required %h", r, 64'd2);
        else n_pass++;
        run_op(c_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hC000_0000_0000_0000) $display("FAIL div_min_2: got %h required %h", r, 64'hC000_0000_0000_0000);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        logic [63:0] r; int lat;
        run_op(c_DIVU, 1'b0, 64'd12345, 64'd0, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL divu_by0: got %h required %h", r, 64'hFFFF_FFFF_FFFF_FFFF);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL lat_divu_by0: got %0d required 2", lat);
        else n_pass++;
        run_op(c_REMU, 1'b0, 64'd12345, 64'd0, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'd12345) $display("FAIL remu_by0: got %h required %h", r, 64'd12345);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL lat_remu_by0: got %0d required 2", lat);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [63:0] r; int lat;
        run_op(c_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'h8000_0000_0000_0000) $display("FAIL div_ovf: got %h required %h", r, 64'h8000_0000_0000_0000);
        else n_pass++;
        run_op(c_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'd0) $display("FAIL rem_ovf: got %h required 0", r);
        else n_pass++;
        run_op(c_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_8000_0000) $display("FAIL divw_ovf: got %h required %h", r, 64'hFFFF_FFFF_8000_0000);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL lat_divw_ovf: got %0d required 2", lat);
        else n_pass++;
    endtask

    task automatic test_word();
        logic [63:0] r; int lat;
        run_op(c_DIVU, 1'b1, 64'h1234_5678_8000_0000, 64'd1, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_8000_0000) $display("FAIL divuw: got %h required %h", r, 64'hFFFF_FFFF_8000_0000);
        else n_pass++;
        n_checks++;
        if (lat !== 34) $display("FAIL lat_divuw: got %0d required 34", lat);
        else n_pass++;
        run_op(c_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd16, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hF) $display("FAIL remuw: got %h required %h", r, 64'hF);
        else n_pass++;
        n_checks++;
        if (lat !== 34) $display("FAIL lat_remuw: got %0d required 34", lat);
        else n_pass++;
        run_op(c_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h0000_0000_0000_0002, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL divw_neg7_2: got %h required %h", r, 64'hFFFF_FFFF_FFFF_FFFD);
        else n_pass++;
        run_op(c_REM, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'h0000_0000_0000_0002, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL remw_neg7_2: got %h required %h", r, 64'hFFFF_FFFF_FFFF_FFFF);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] r; int lat;
        run_op(c_DIVU, 1'b0, 64'd100, 64'd7, 1'b0, r, lat);
        n_checks++;
        if (r !== 64'd14) $display("FAIL bp_result: got %h required %h", r, 64'd14);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || result !== 64'd14 || in_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: out_valid=%b result=%h in_ready=%b required 1/%h/0",
                         i, out_valid, result, in_ready, 64'd14);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [63:0] r; int lat; bit seen;
        @(negedge clk);
        op = c_DIV; word = 1'b0; dividend = 64'd1000; divisor = 64'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b required 0", out_valid);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL flush_idle: in_ready=%b required 1", in_ready);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL flush_no_result: out_valid seen=%b required 0", seen);
        else n_pass++;
        // Request presented together with flush must be dropped
        @(negedge clk);
        op = c_DIVU; dividend = 64'd5; divisor = 64'd0; in_valid = 1'b1; flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_blocks_ready: in_ready=%b required 0", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL flush_no_accept: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else n_pass++;
        run_op(c_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 66)
            $display("FAIL post_flush_op: result=%h lat=%0d required %h/66", r, lat, 64'hFFFF_FFFF_FFFF_FFFF);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; int lat;
        @(negedge clk);
        op = c_DIVU; word = 1'b0; dividend = 64'd999; divisor = 64'd10; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 64'd0)
            $display("FAIL async_reset: out_valid=%b result=%h required 0/0", out_valid, result);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; int lat;
        run_op(c_REMU, 1'b0, 64'd100, 64'd7, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'd2) $display("FAIL b2b_remu: got %h required %h", r, 64'd2);
        else n_pass++;
        run_op(c_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b1, r, lat);
        n_checks++;
        if (r !== 64'h0FFF_FFFF_FFFF_FFFF) $display("FAIL b2b_divu_big: got %h required %h", r, 64'h0FFF_FFFF_FFFF_FFFF);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_signed();
        test_div_zero();
        test_overflow();
        test_word();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider for the RV64M divide group: DIV, DIVU, REM, REMU and their W variants.
- Sits in the execute stage beside the single-cycle ALU.
- Accepts one request over a valid/ready handshake, iterates, then holds the result until the writeback side accepts it.
- Only one operation is in flight at a time; a flush input kills it.

Parameters:
BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; legal values 1, 2, 4 (must divide 32)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  pipeline kill; aborts any in-flight or completed operation
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
word  input  1  1 = W variant (32-bit operate, 64-bit sign-extended result)
dividend  input  64  rs1 value
divisor  input  64  rs2 value
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  64  quotient or remainder

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, result=0, all internal registers 0. Reset mid-operation discards the operation silently.
- in_ready = (state==IDLE) && !flush. A request is accepted on the rising edge where in_valid && in_ready.
- At accept, latch op, word and the operands.
  - word=1: use bits [31:0] only.
  - Signed ops (DIV, REM): take absolute values; record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
  - Unsigned ops: use operands as-is.
- States:
  - IDLE: on accept, go to SPECIAL if divisor (effective width) is 0, or if signed and dividend = most-negative and divisor = -1; otherwise go to CALC with iteration counter N = (word ? 32 : 64) / BITS_PER_CYCLE.
  - CALC: each cycle, shift {rem,quo} left by one bit and trial-subtract the divisor; repeat BITS_PER_CYCLE times combinationally. Decrement the counter; when it reaches 0, go to FIXUP.
  - FIXUP: apply sign correction (two's-complement negate of quotient/remainder per the recorded signs). Select quotient for DIV/DIVU or remainder for REM/REMU. If word=1, sign-extend bit 31 to 64 bits (this applies to DIVUW/REMUW as well). Register the value into result, set out_valid, go to DONE.
  - SPECIAL: register the special result, set out_valid, go to DONE.
    - Divide by zero: quotient = all ones (after W sign-extension, 64'hFFFF_FFFF_FFFF_FFFF); remainder = dividend (W: sign-extended dividend[31:0]).
    - Signed overflow: quotient = dividend (W: sign-extended 32'h8000_0000); remainder = 0.
  - DONE: hold result and out_valid stable. On out_valid && out_ready, clear out_valid and go to IDLE. A new request is acceptable from the next cycle; there is no same-cycle turnaround.
- Latency (accept edge = cycle 0, BITS_PER_CYCLE=1):
  - 64-bit op: out_valid high at cycle 66.
  - W op: out_valid high at cycle 34.
  - Special case: out_valid high at cycle 2.
  - General form: 2 + N cycles.
- flush:
  - In any state, next state = IDLE and out_valid=0 on the next edge; result is not cleared.
  - flush has priority over out_ready and in_valid in the same cycle; no request is accepted while flush is high.
- result changes only on entry to DONE. Its value outside DONE is don't-care for checkers, except that it is 0 after reset.
- Width rules: all arithmetic is 64-bit internally. The remainder register is 65 bits so the trial subtract carries out. Negating the most-negative value wraps (64'h8000_0000_0000_0000 stays itself).

Test Plan:
- DIV: dividend=-7 (64'hFFFF_FFFF_FFFF_FFF9), divisor=2 -> result=64'hFFFF_FFFF_FFFF_FFFD (-3). REM with the same operands -> 64'hFFFF_FFFF_FFFF_FFFF (-1). out_valid asserts exactly 66 cycles after accept.
- Divide by zero: DIVU 12345/0 -> 64'hFFFF_FFFF_FFFF_FFFF. REMU 12345/0 -> 12345. Both with out_valid 2 cycles after accept.
- Overflow: DIV 64'h8000_0000_0000_0000 / -1 -> 64'h8000_0000_0000_0000. REM with the same operands -> 0. DIVW with dividend=64'h0000_0000_8000_0000, divisor=-1 -> 64'hFFFF_FFFF_8000_0000.
- W variants: DIVUW 64'h1234_5678_8000_0000 / 1 -> 64'hFFFF_FFFF_8000_0000. REMUW 64'h0000_0000_FFFF_FFFF / 16 -> 64'hF. out_valid 34 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and out_valid are stable and in_ready=0. Raise out_ready -> out_valid drops next cycle and in_ready rises.
- Flush/reset: assert flush at CALC cycle 20 -> IDLE next cycle, no out_valid, next request computes correctly. Pulse rst_n low mid-CALC -> out_valid=0 and result=0 immediately, in_ready=1 after release.
